// File: rtl/ram_arb_pkg.sv
// Shared types for the two-port RAM arbiter: ownership states and port indices.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/RAM.sv
// Single-port RAM: asynchronous read, synchronous write when load is high.
module RAM #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             load,
    input  logic [DEPTH-1:0] address,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] mem_q [0:(1<<DEPTH)-1];

    always_ff @(posedge clk) begin
        if (load) begin
            mem_q[address] <= in;
        end
    end

    assign out = mem_q[address];

endmodule

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker; on a tie the port that did not win last goes.
module rr_pick2
    import ram_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic gnt0,
    output logic gnt1
);

    assign gnt0 = req0 & (~req1 | (last == PORT1));
    assign gnt1 = req1 & (~req0 | (last == PORT0));

endmodule

// File: rtl/ram_arbiter.sv
// Two-master arbiter in front of a single-port RAM: one access per cycle,
// round-robin on contention, bounded locked bursts, registered read data.
//
// state | meaning
// IDLE  | no ownership, round-robin arbitration
// OWN0  | port 0 holds a locked burst
// OWN1  | port 1 holds a locked burst
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 3,
    parameter int MAX_LOCK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic             lock0,
    input  logic             lock1,
    input  logic [DEPTH-1:0] addr0,
    input  logic [DEPTH-1:0] addr1,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             rvalid0,
    output logic             rvalid1,
    output logic [WIDTH-1:0] rdata,
    output logic             ram_load,
    output logic [DEPTH-1:0] ram_address,
    output logic [WIDTH-1:0] ram_in,
    input  logic [WIDTH-1:0] ram_out
);

    localparam int LOCK_W = $clog2(MAX_LOCK);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(MAX_LOCK - 1);

    arb_state_e        state_q, state_d;
    logic              last_q, last_d;
    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d, base_cnt;
    logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [WIDTH-1:0]  rdata_q, rdata_d;
    logic              pick0, pick1, own_hit0, own_hit1;

    rr_pick2 u_pick (
        .req0 (req0),
        .req1 (req1),
        .last (last_q),
        .gnt0 (pick0),
        .gnt1 (pick1)
    );

    // An owner that still requests wins outright; otherwise fall back to round-robin.
    always_comb begin
        own_hit0 = (state_q == OWN0) && req0;
        own_hit1 = (state_q == OWN1) && req1;
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        if (rst_n) begin
            if (own_hit0) begin
                gnt0 = 1'b1;
            end else if (own_hit1) begin
                gnt1 = 1'b1;
            end else begin
                gnt0 = pick0;
                gnt1 = pick1;
            end
        end
    end

    assign ram_address = gnt1 ? addr1 : addr0;
    assign ram_in      = gnt1 ? wdata1 : wdata0;
    assign ram_load    = (gnt0 & we0) | (gnt1 & we1);

    // A fresh grant from normal arbitration starts its burst count at zero.
    always_comb begin
        base_cnt   = (own_hit0 || own_hit1) ? lock_cnt_q : '0;
        state_d    = IDLE;
        lock_cnt_d = '0;
        last_d     = last_q;
        rvalid0_d  = gnt0 & ~we0;
        rvalid1_d  = gnt1 & ~we1;
        rdata_d    = (rvalid0_d | rvalid1_d) ? ram_out : rdata_q;
        if (gnt0) begin
            last_d = PORT0;
            if (lock0 && (base_cnt < LOCK_LAST)) begin
                state_d    = OWN0;
                lock_cnt_d = base_cnt + LOCK_W'(1);
            end
        end else if (gnt1) begin
            last_d = PORT1;
            if (lock1 && (base_cnt < LOCK_LAST)) begin
                state_d    = OWN1;
                lock_cnt_d = base_cnt + LOCK_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_q     <= PORT1;
            lock_cnt_q <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            lock_cnt_q <= lock_cnt_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            rdata_q    <= rdata_d;
        end
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter driving a real RAM: per-cycle behavioural model plus directed literal checks.
module tb_ram_arbiter;

    localparam int WIDTH    = 16;
    localparam int DEPTH    = 3;
    localparam int MAX_LOCK = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0, req1, we0, we1, lock0, lock1;
    logic [DEPTH-1:0] addr0, addr1;
    logic [WIDTH-1:0] wdata0, wdata1;
    logic             gnt0, gnt1, rvalid0, rvalid1, ram_load;
    logic [WIDTH-1:0] rdata, ram_in, ram_out;
    logic [DEPTH-1:0] ram_address;

    int tests = 0;
    int fails = 0;

    ram_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .ram_load(ram_load), .ram_address(ram_address),
        .ram_in(ram_in), .ram_out(ram_out)
    );

    RAM #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
        .clk(clk), .load(ram_load), .address(ram_address), .in(ram_in), .out(ram_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: owner as an integer, burst length counted in grants.
    int          m_own = -1;
    int          m_burst = 0;
    int          m_last = 1;
    int          m_w;
    bit          m_ok = 1'b0;
    bit          m_rv0 = 1'b0, m_rv1 = 1'b0;
    logic [15:0] m_rdata = '0;
    logic [15:0] m_mem [8];
    logic        m_lock;

    always @(negedge clk) begin
        m_w = -1;
        if (rst_n) begin
            if (m_own == 0 && req0)      m_w = 0;
            else if (m_own == 1 && req1) m_w = 1;
            else if (req0 && req1)       m_w = 1 - m_last;
            else if (req0)               m_w = 0;
            else if (req1)               m_w = 1;
        end
        if (m_ok) begin
            chk("m_gnt0", gnt0, m_w == 0);
            chk("m_gnt1", gnt1, m_w == 1);
            chk("m_load", ram_load, (m_w == 0) ? we0 : (m_w == 1) ? we1 : 1'b0);
            if (m_w >= 0) begin
                chk("m_addr", ram_address, (m_w == 0) ? addr0 : addr1);
                chk("m_wdata", ram_in, (m_w == 0) ? wdata0 : wdata1);
            end
            chk("m_rvalid0", rvalid0, m_rv0);
            chk("m_rvalid1", rvalid1, m_rv1);
            chk("m_rdata", rdata, m_rdata);
        end
        if (!rst_n) begin
            m_ok = 1'b1; m_own = -1; m_burst = 0; m_last = 1;
            m_rv0 = 1'b0; m_rv1 = 1'b0; m_rdata = '0;
        end else if (m_w >= 0) begin
            m_lock = (m_w == 0) ? lock0 : lock1;
            m_burst = (m_own == m_w) ? m_burst + 1 : 1;
            m_last = m_w;
            if (m_lock && m_burst < MAX_LOCK) m_own = m_w;
            else begin m_own = -1; m_burst = 0; end
            m_rv0 = (m_w == 0) && !we0;
            m_rv1 = (m_w == 1) && !we1;
            if (m_w == 0 && we0) m_mem[addr0] = wdata0;
            if (m_w == 1 && we1) m_mem[addr1] = wdata1;
            if (m_rv0) m_rdata = m_mem[addr0];
            if (m_rv1) m_rdata = m_mem[addr1];
        end else begin
            m_own = -1; m_burst = 0; m_rv0 = 1'b0; m_rv1 = 1'b0;
        end
    end

    logic             s_gnt0, s_gnt1, s_rv0, s_rv1, s_load;
    logic [WIDTH-1:0] s_rdata;

    task automatic step();
        @(negedge clk);
        s_gnt0 = gnt0; s_gnt1 = gnt1; s_rv0 = rvalid0; s_rv1 = rvalid1;
        s_load = ram_load; s_rdata = rdata;
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic r, input logic w, input logic l, input logic [2:0] a, input logic [15:0] d);
        req0 = r; we0 = w; lock0 = l; addr0 = a; wdata0 = d;
    endtask

    task automatic set1(input logic r, input logic w, input logic l, input logic [2:0] a, input logic [15:0] d);
        req1 = r; we1 = w; lock1 = l; addr1 = a; wdata1 = d;
    endtask

    function automatic logic [15:0] fill_val(input int i);
        return 16'h1000 + 16'(i) * 16'h0111;
    endfunction

    function automatic logic [15:0] final_val(input int i);
        return (i == 5) ? 16'hBEEF : fill_val(i);
    endfunction

    initial begin
        rst_n = 1'b0;
        set0(1, 1, 0, 3'd1, 16'hDEAD);
        set1(1, 1, 0, 3'd2, 16'hDEAD);
        step();
        chk("rst_gnt0", s_gnt0, 0);
        chk("rst_gnt1", s_gnt1, 0);
        chk("rst_load", s_load, 0);
        step();
        chk("rst_rvalid0", s_rv0, 0);
        chk("rst_rvalid1", s_rv1, 0);
        chk("rst_rdata", s_rdata, 0);

        // Fill the RAM through port 0.
        rst_n = 1'b1;
        set1(0, 0, 0, 3'd0, 16'h0);
        for (int i = 0; i < 8; i++) begin
            set0(1, 1, 0, i[2:0], fill_val(i));
            step();
            chk("fill_gnt0", s_gnt0, 1);
            chk("fill_load", s_load, 1);
        end

        // Fresh reset, then both ports read continuously.
        set0(0, 0, 0, 3'd0, 16'h0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        set0(1, 0, 0, 3'd2, 16'h0);
        set1(1, 0, 0, 3'd3, 16'h0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("tie_gnt0", s_gnt0, (i % 2) == 0);
            chk("tie_gnt1", s_gnt1, (i % 2) == 1);
            if (i > 0) begin
                chk("tie_rvalid0", s_rv0, (i % 2) == 1);
                chk("tie_rvalid1", s_rv1, (i % 2) == 0);
                chk("tie_rdata", s_rdata, ((i % 2) == 1) ? 16'h1222 : 16'h1333);
            end
        end

        // Write then read-back across ports.
        set1(0, 0, 0, 3'd0, 16'h0);
        set0(1, 1, 0, 3'd5, 16'hBEEF);
        step();
        chk("beef_wr_gnt0", s_gnt0, 1);
        set0(0, 0, 0, 3'd0, 16'h0);
        set1(1, 0, 0, 3'd5, 16'h0);
        step();
        chk("beef_rd_gnt1", s_gnt1, 1);
        set1(0, 0, 0, 3'd0, 16'h0);
        step();
        chk("beef_rvalid1", s_rv1, 1);
        chk("beef_rdata", s_rdata, 16'hBEEF);

        // Port 0 wins once so port 1 takes the next tie, then port 1 locks.
        set0(1, 0, 0, 3'd0, 16'h0);
        step();
        set1(1, 0, 1, 3'd1, 16'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("lock_gnt1", s_gnt1, i < 4);
            chk("lock_gnt0", s_gnt0, i == 4);
        end
        set0(0, 0, 0, 3'd0, 16'h0);
        set1(0, 0, 0, 3'd0, 16'h0);
        step();

        // Port 0 locks, port 1 waits, port 0 drops its request.
        set0(1, 0, 1, 3'd6, 16'h0);
        step();
        chk("rel_gnt0_a", s_gnt0, 1);
        set1(1, 0, 0, 3'd7, 16'h0);
        step();
        chk("rel_gnt0_b", s_gnt0, 1);
        chk("rel_gnt1_b", s_gnt1, 0);
        set0(0, 0, 0, 3'd0, 16'h0);
        step();
        chk("rel_gnt1_c", s_gnt1, 1);
        set1(0, 0, 0, 3'd0, 16'h0);
        step();
        chk("rel_rvalid1", s_rv1, 1);
        chk("rel_rdata", s_rdata, 16'h1777);

        // Reset in the middle of a port 1 burst.
        set1(1, 0, 1, 3'd4, 16'h0);
        step();
        chk("rb_gnt1", s_gnt1, 1);
        rst_n = 1'b0;
        set0(1, 1, 0, 3'd4, 16'hDEAD);
        step();
        chk("rb_gnt0", s_gnt0, 0);
        chk("rb_gnt1", s_gnt1, 0);
        chk("rb_load", s_load, 0);
        set0(1, 0, 0, 3'd4, 16'h0);
        set1(1, 0, 1, 3'd3, 16'h0);
        step();
        chk("rb_rvalid1", s_rv1, 0);
        chk("rb_gnt1_hold", s_gnt1, 0);
        chk("rb_load_hold", s_load, 0);
        rst_n = 1'b1;
        step();
        chk("rb_first_tie", s_gnt0, 1);
        set0(0, 0, 0, 3'd0, 16'h0);
        set1(0, 0, 0, 3'd0, 16'h0);
        step();
        chk("rb_rvalid0", s_rv0, 1);
        chk("rb_no_write", s_rdata, 16'h1444);

        // Port 1 streams reads over the whole RAM.
        for (int i = 0; i < 8; i++) begin
            set1(1, 0, 0, i[2:0], 16'h0);
            step();
            chk("seq_gnt1", s_gnt1, 1);
            if (i > 0) begin
                chk("seq_rvalid1", s_rv1, 1);
                chk("seq_rdata", s_rdata, final_val(i - 1));
            end
        end
        set1(0, 0, 0, 3'd0, 16'h0);
        step();
        chk("seq_rvalid1_last", s_rv1, 1);
        chk("seq_rdata_last", s_rdata, final_val(7));
        step();
        chk("seq_rvalid1_end", s_rv1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter that shares one single-port `RAM` (async read, write on posedge when `load`) between two masters, e.g. the CPU data port and a screen/DMA engine. Grants one access per cycle with round-robin fairness and optional bounded locked bursts. Registers read data toward the winner. Sits directly in front of the `RAM` instance; its `ram_*` outputs drive `RAM.load/address/in`, and `RAM.out` feeds back.

## Interface
- `WIDTH`, 16, data width (matches `RAM.WIDTH`)
- `DEPTH`, 3, address width in bits (matches `RAM.DEPTH`)
- `MAX_LOCK`, 4, max consecutive locked grants to one port (≥2)

- `clk` in 1, the single clock; all state updates on posedge
- `rst_n` in 1, reset, synchronous, active-low
- `req0`/`req1` in 1, access request; held until granted
- `we0`/`we1` in 1, 1 = write, 0 = read; valid with req
- `lock0`/`lock1` in 1, request to keep ownership next cycle
- `addr0`/`addr1` in DEPTH, access address
- `wdata0`/`wdata1` in WIDTH, write data
- `gnt0`/`gnt1` out 1, access performed this cycle (combinational, one-hot or zero)
- `rvalid0`/`rvalid1` out 1, `rdata` valid for that port (registered)
- `rdata` out WIDTH, read data, shared
- `ram_load` out 1, to `RAM.load`
- `ram_address` out DEPTH, to `RAM.address`
- `ram_in` out WIDTH, to `RAM.in`
- `ram_out` in WIDTH, from `RAM.out`

## Operation
- States: `IDLE` (no ownership), `OWN0`, `OWN1` (locked burst in progress).
- IDLE: exactly one requester → grant it. Both requesting → grant the port ≠ `last` (round-robin pointer). Winner k updates `last`=k.
- Granted port k with `lockk`=1 and `lock_cnt` < MAX_LOCK-1: next state `OWNk`, `lock_cnt`+1. Otherwise next state IDLE, `lock_cnt`=0.
- OWNk: port k wins unconditionally if `reqk`=1, even if the other port requests. If `reqk`=0: leave to IDLE in the same cycle and arbitrate normally. Forced release after MAX_LOCK consecutive grants → IDLE, `last`=k, so the other port wins next on contention.
- Mux: `ram_address`=addr of winner, `ram_in`=wdata of winner, `ram_load`=gnt & we of winner; with no grant, `ram_load`=0 and address/in = port 0 values.
- Read (we=0) granted at cycle N: `rdata`←`ram_out` at end of N; `rvalidk`=1 during N+1 only. `rdata` holds its value otherwise.
- Write granted at N: RAM updated at end of N; no rvalid.
- Requester drops or changes req/addr/wdata only after sampling its gnt.

## Timing
- Reset (`rst_n`=0 at posedge): state IDLE, `last`=1 (port 0 wins first tie), `lock_cnt`=0, `rvalid0/1`=0, `rdata`=0. While `rst_n`=0, `gnt0/1`=0 and `ram_load`=0 combinationally.
- Reset mid-burst: ownership and pending rvalid dropped; no write occurs in the reset cycle.
- Grant latency 0 cycles (same cycle as req if it wins). Read latency 1 cycle (gnt → rvalid).
- Back-to-back reads from one port: rvalid every cycle, pipelined.
- Throughput: one access per cycle, never idle while any req=1.
- `gnt0 & gnt1` never 1.

## Structure
- Package `ram_arb_pkg`: state enum (`IDLE`, `OWN0`, `OWN1`), port index constants.
- Sub-module `rr_pick2`: combinational 2-way round-robin picker (req0, req1, last → gnt0, gnt1). Everything else lives in `ram_arbiter`.
- Bench instantiates `ram_arbiter` + `RAM` (WIDTH=16, DEPTH=3) and checks against a behavioural model.

## Test plan
- After reset: req0=req1=1, both reads → gnt0 in cycle 1, gnt1 in cycle 2, alternating thereafter; rvalid follows each gnt by 1 cycle.
- Port 0 writes 16'hBEEF to addr 5; next cycle port 1 reads addr 5 → `rvalid1`=1 with `rdata`=16'hBEEF.
- Port 1 holds lock1=1, req1=1, with port 0 requesting → gnt1 for exactly 4 cycles (MAX_LOCK), then gnt0.
- Lock release: port 0 locks, drops req0 after 2 grants with req1 pending → gnt1 in the very next cycle.
- `rst_n`=0 asserted during an OWN1 burst with a read pending → next cycle `rvalid1`=0, `gnt0/1`=0, `ram_load`=0; after release, port 0 wins the first tie.
- Single requester port 1 reads addrs 0..7 back-to-back → 8 consecutive gnt1 and 8 consecutive rvalid1 with the correct data, no bubbles.
